// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: flush > hold > load-use bubble > capture > idle bubble.
// Define ID_EX_PERF_CNT_EN to build the bubble/flush/hold performance counters.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XREG_ADDRWIDTH
`define XREG_ADDRWIDTH 5
`endif
`ifndef NO_LOAD
`define NO_LOAD 5'd0
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef ZERO_32BIT
`define ZERO_32BIT 32'h0000_0000
`endif

module id_ex_reg #(
    parameter int ALU_OP_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [`XLEN-1:0]           rs1_data_id,
    input  logic [`XLEN-1:0]           rs2_data_id,
    input  logic [`XLEN-1:0]           imm_id,
    input  logic [`XLEN-1:0]           pc_id,
    input  logic [ALU_OP_W-1:0]        alu_op_id,
    input  logic                       rd_en_id,
    input  logic [`XREG_ADDRWIDTH-1:0] rd_addr_id,
    input  logic [4:0]                 load_flag_id,
    input  logic                       load_hazerd_stall,
    input  logic                       flush_ex,
    input  logic                       ex_ready,
    input  logic                       perf_clr,
    output logic                       id_ready,
    output logic                       ex_valid,
    output logic [`XLEN-1:0]           rs1_ex,
    output logic [`XLEN-1:0]           rs2_ex,
    output logic [`XLEN-1:0]           imm_ex,
    output logic [`XLEN-1:0]           pc_ex,
    output logic [ALU_OP_W-1:0]        alu_op_ex,
    output logic                       rd_en_ex,
    output logic [`XREG_ADDRWIDTH-1:0] rd_addr_ex,
    output logic [4:0]                 load_flag_ex,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           flush_cnt,
    output logic [CNT_W-1:0]           hold_cnt
);

    typedef enum logic [2:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_CAPTURE,
        ACT_IDLE
    } action_e;

    action_e action;

    assign id_ready = ex_ready & ~load_hazerd_stall;

    always_comb begin
        action = ACT_IDLE;
        if (flush_ex)
            action = ACT_FLUSH;
        else if (!ex_ready)
            action = ACT_HOLD;
        else if (load_hazerd_stall)
            action = ACT_BUBBLE;
        else if (id_valid)
            action = ACT_CAPTURE;
    end

    // Flush, load-use and idle cycles all load the same empty bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            rs1_ex       <= '0;
            rs2_ex       <= '0;
            imm_ex       <= '0;
            pc_ex        <= '0;
            alu_op_ex    <= '0;
            rd_en_ex     <= `FALSE;
            rd_addr_ex   <= '0;
            load_flag_ex <= `NO_LOAD;
        end else begin
            case (action)
                ACT_HOLD: begin
                end
                ACT_CAPTURE: begin
                    ex_valid     <= 1'b1;
                    rs1_ex       <= rs1_data_id;
                    rs2_ex       <= rs2_data_id;
                    imm_ex       <= imm_id;
                    pc_ex        <= pc_id;
                    alu_op_ex    <= alu_op_id;
                    rd_en_ex     <= rd_en_id & (rd_addr_id != '0);
                    rd_addr_ex   <= rd_addr_id;
                    load_flag_ex <= load_flag_id;
                end
                default: begin
                    ex_valid     <= 1'b0;
                    rs1_ex       <= '0;
                    rs2_ex       <= '0;
                    imm_ex       <= '0;
                    pc_ex        <= '0;
                    alu_op_ex    <= '0;
                    rd_en_ex     <= `FALSE;
                    rd_addr_ex   <= '0;
                    load_flag_ex <= `NO_LOAD;
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] hold_q;

    // Saturating event counters; only load-use bubbles count, not idle ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
            flush_q  <= '0;
            hold_q   <= '0;
        end else if (perf_clr) begin
            bubble_q <= '0;
            flush_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (action == ACT_BUBBLE && bubble_q != '1)
                bubble_q <= bubble_q + CNT_ONE;
            if (action == ACT_FLUSH && flush_q != '1)
                flush_q <= flush_q + CNT_ONE;
            if (action == ACT_HOLD && hold_q != '1)
                hold_q <= hold_q + CNT_ONE;
        end
    end

    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
    assign hold_cnt   = hold_q;
`else
    logic perf_clr_unused;

    assign perf_clr_unused = perf_clr;
    assign bubble_cnt      = '0;
    assign flush_cnt       = '0;
    assign hold_cnt        = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: vector table for the per-cycle priority, plus
// sequences for multi-cycle hold, stall, flush, counter and async reset cases.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XREG_ADDRWIDTH
`define XREG_ADDRWIDTH 5
`endif
`ifndef NO_LOAD
`define NO_LOAD 5'd0
`endif

module tb_id_ex_reg;

    localparam int ALU_OP_W = 6;
    localparam int CNT_W    = 32;
`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] rs1_data_id, rs2_data_id, imm_id, pc_id;
    logic [5:0]  alu_op_id;
    logic        rd_en_id;
    logic [4:0]  rd_addr_id;
    logic [4:0]  load_flag_id;
    logic        load_hazerd_stall, flush_ex, ex_ready, perf_clr;
    logic        id_ready, ex_valid;
    logic [31:0] rs1_ex, rs2_ex, imm_ex, pc_ex;
    logic [5:0]  alu_op_ex;
    logic        rd_en_ex;
    logic [4:0]  rd_addr_ex;
    logic [4:0]  load_flag_ex;
    logic [31:0] bubble_cnt, flush_cnt, hold_cnt;

    logic        sat_id_ready, sat_ex_valid, sat_rd_en_ex;
    logic [31:0] sat_rs1_ex, sat_rs2_ex, sat_imm_ex, sat_pc_ex;
    logic [5:0]  sat_alu_op_ex;
    logic [4:0]  sat_rd_addr_ex, sat_load_flag_ex;
    logic [1:0]  sat_bubble_cnt, sat_flush_cnt, sat_hold_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
        .imm_id(imm_id), .pc_id(pc_id), .alu_op_id(alu_op_id),
        .rd_en_id(rd_en_id), .rd_addr_id(rd_addr_id), .load_flag_id(load_flag_id),
        .load_hazerd_stall(load_hazerd_stall), .flush_ex(flush_ex),
        .ex_ready(ex_ready), .perf_clr(perf_clr), .id_ready(id_ready),
        .ex_valid(ex_valid), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .imm_ex(imm_ex),
        .pc_ex(pc_ex), .alu_op_ex(alu_op_ex), .rd_en_ex(rd_en_ex),
        .rd_addr_ex(rd_addr_ex), .load_flag_ex(load_flag_ex),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
    );

    // Narrow-counter instance used only to observe saturation.
    id_ex_reg #(.ALU_OP_W(ALU_OP_W), .CNT_W(2)) sat_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
        .imm_id(imm_id), .pc_id(pc_id), .alu_op_id(alu_op_id),
        .rd_en_id(rd_en_id), .rd_addr_id(rd_addr_id), .load_flag_id(load_flag_id),
        .load_hazerd_stall(load_hazerd_stall), .flush_ex(flush_ex),
        .ex_ready(ex_ready), .perf_clr(perf_clr), .id_ready(sat_id_ready),
        .ex_valid(sat_ex_valid), .rs1_ex(sat_rs1_ex), .rs2_ex(sat_rs2_ex),
        .imm_ex(sat_imm_ex), .pc_ex(sat_pc_ex), .alu_op_ex(sat_alu_op_ex),
        .rd_en_ex(sat_rd_en_ex), .rd_addr_ex(sat_rd_addr_ex),
        .load_flag_ex(sat_load_flag_ex), .bubble_cnt(sat_bubble_cnt),
        .flush_cnt(sat_flush_cnt), .hold_cnt(sat_hold_cnt)
    );

    typedef struct {
        logic        iv, st, fl, rdy;
        logic [31:0] pc, rs1, rs2, imm;
        logic [5:0]  alu;
        logic        rde;
        logic [4:0]  rda, lf;
        logic        e_rdy, e_val;
        logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
        logic [5:0]  e_alu;
        logic        e_rde;
        logic [4:0]  e_rda, e_lf;
    } vec_t;

    function automatic vec_t mkVec(
        input logic iv, st, fl, rdy,
        input logic [31:0] pc, rs1, rs2, imm, input logic [5:0] alu,
        input logic rde, input logic [4:0] rda, lf,
        input logic e_rdy, e_val,
        input logic [31:0] e_pc, e_rs1, e_rs2, e_imm, input logic [5:0] e_alu,
        input logic e_rde, input logic [4:0] e_rda, e_lf);
        vec_t v;
        v.iv = iv; v.st = st; v.fl = fl; v.rdy = rdy;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.alu = alu;
        v.rde = rde; v.rda = rda; v.lf = lf;
        v.e_rdy = e_rdy; v.e_val = e_val;
        v.e_pc = e_pc; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_imm = e_imm;
        v.e_alu = e_alu; v.e_rde = e_rde; v.e_rda = e_rda; v.e_lf = e_lf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid = v.iv; load_hazerd_stall = v.st; flush_ex = v.fl; ex_ready = v.rdy;
        pc_id = v.pc; rs1_data_id = v.rs1; rs2_data_id = v.rs2; imm_id = v.imm;
        alu_op_id = v.alu; rd_en_id = v.rde; rd_addr_id = v.rda; load_flag_id = v.lf;
        perf_clr = 1'b0;
    endtask

    task automatic setCtl(input logic iv, st, fl, rdy, clr);
        id_valid = iv; load_hazerd_stall = st; flush_ex = fl; ex_ready = rdy; perf_clr = clr;
    endtask

    task automatic setData(input logic [31:0] pc, input logic rde,
                           input logic [4:0] rda, lf);
        pc_id = pc; rs1_data_id = pc + 32'h1; rs2_data_id = pc + 32'h2;
        imm_id = pc + 32'h3; alu_op_id = 6'h11; rd_en_id = rde;
        rd_addr_id = rda; load_flag_id = lf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string name, input int eb, ef, eh);
        checkOutput({name, ".bubble_cnt"}, bubble_cnt, PERF ? 32'(eb) : 32'h0);
        checkOutput({name, ".flush_cnt"},  flush_cnt,  PERF ? 32'(ef) : 32'h0);
        checkOutput({name, ".hold_cnt"},   hold_cnt,   PERF ? 32'(eh) : 32'h0);
    endtask

    task automatic checkBubble(input string name);
        checkOutput({name, ".ex_valid"},     32'(ex_valid),     32'h0);
        checkOutput({name, ".pc_ex"},        pc_ex,             32'h0);
        checkOutput({name, ".rd_en_ex"},     32'(rd_en_ex),     32'h0);
        checkOutput({name, ".rd_addr_ex"},   32'(rd_addr_ex),   32'h0);
        checkOutput({name, ".load_flag_ex"}, 32'(load_flag_ex), 32'(`NO_LOAD));
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mkVec(1,0,0,1, 32'h100,32'h11,32'h22,32'h33,6'h03,1,5'd5,5'd0,  1,1,32'h100,32'h11,32'h22,32'h33,6'h03,1,5'd5,5'd0));
        vecs.push_back(mkVec(1,0,0,1, 32'h104,32'h12,32'h23,32'h34,6'h04,1,5'd5,5'd0,  1,1,32'h104,32'h12,32'h23,32'h34,6'h04,1,5'd5,5'd0));
        vecs.push_back(mkVec(1,0,0,1, 32'h108,32'h13,32'h24,32'h35,6'h05,1,5'd5,5'd0,  1,1,32'h108,32'h13,32'h24,32'h35,6'h05,1,5'd5,5'd0));
        vecs.push_back(mkVec(1,0,0,1, 32'h10C,32'hAA,32'hBB,32'hCC,6'h07,1,5'd7,5'd2,  1,1,32'h10C,32'hAA,32'hBB,32'hCC,6'h07,1,5'd7,5'd2));
        vecs.push_back(mkVec(1,1,0,1, 32'h110,32'h1,32'h2,32'h3,6'h08,1,5'd8,5'd2,     0,0,32'h0,32'h0,32'h0,32'h0,6'h00,0,5'd0,`NO_LOAD));
        vecs.push_back(mkVec(1,0,0,1, 32'h110,32'h1,32'h2,32'h3,6'h08,1,5'd8,5'd0,     1,1,32'h110,32'h1,32'h2,32'h3,6'h08,1,5'd8,5'd0));
        vecs.push_back(mkVec(1,0,0,0, 32'h999,32'h9,32'h9,32'h9,6'h09,1,5'd9,5'd3,     0,1,32'h110,32'h1,32'h2,32'h3,6'h08,1,5'd8,5'd0));
        vecs.push_back(mkVec(1,0,1,0, 32'h999,32'h9,32'h9,32'h9,6'h09,1,5'd9,5'd3,     0,0,32'h0,32'h0,32'h0,32'h0,6'h00,0,5'd0,`NO_LOAD));
        vecs.push_back(mkVec(1,0,0,0, 32'h777,32'h7,32'h7,32'h7,6'h07,1,5'd7,5'd1,     0,0,32'h0,32'h0,32'h0,32'h0,6'h00,0,5'd0,`NO_LOAD));
        vecs.push_back(mkVec(1,0,0,1, 32'h120,32'h5,32'h6,32'h7,6'h02,1,5'd0,5'd0,     1,1,32'h120,32'h5,32'h6,32'h7,6'h02,0,5'd0,5'd0));
        vecs.push_back(mkVec(0,0,0,1, 32'h124,32'h5,32'h6,32'h7,6'h02,1,5'd4,5'd1,     1,0,32'h0,32'h0,32'h0,32'h0,6'h00,0,5'd0,`NO_LOAD));
        vecs.push_back(mkVec(1,0,0,1, 32'h130,32'hDEAD,32'hBEEF,32'hF00,6'h3F,0,5'd31,5'd4, 1,1,32'h130,32'hDEAD,32'hBEEF,32'hF00,6'h3F,0,5'd31,5'd4));
        vecs.push_back(mkVec(1,1,0,0, 32'h134,32'h1,32'h1,32'h1,6'h01,1,5'd1,5'd1,     0,1,32'h130,32'hDEAD,32'hBEEF,32'hF00,6'h3F,0,5'd31,5'd4));
        vecs.push_back(mkVec(1,0,1,1, 32'h134,32'h1,32'h1,32'h1,6'h01,1,5'd1,5'd1,     1,0,32'h0,32'h0,32'h0,32'h0,6'h00,0,5'd0,`NO_LOAD));
        vecs.push_back(mkVec(1,0,0,1, 32'h134,32'h1,32'h2,32'h3,6'h3F,1,5'd31,5'd1,    1,1,32'h134,32'h1,32'h2,32'h3,6'h3F,1,5'd31,5'd1));

        rst = 1'b1;
        setCtl(0, 0, 0, 1, 0);
        setData(32'h0, 0, 5'd0, `NO_LOAD);
        #2;
        checkBubble("reset");
        checkCounters("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.id_ready", i), 32'(id_ready), 32'(vecs[i].e_rdy));
            tick();
            checkOutput($sformatf("v%0d.ex_valid", i),     32'(ex_valid),     32'(vecs[i].e_val));
            checkOutput($sformatf("v%0d.pc_ex", i),        pc_ex,             vecs[i].e_pc);
            checkOutput($sformatf("v%0d.rs1_ex", i),       rs1_ex,            vecs[i].e_rs1);
            checkOutput($sformatf("v%0d.rs2_ex", i),       rs2_ex,            vecs[i].e_rs2);
            checkOutput($sformatf("v%0d.imm_ex", i),       imm_ex,            vecs[i].e_imm);
            checkOutput($sformatf("v%0d.alu_op_ex", i),    32'(alu_op_ex),    32'(vecs[i].e_alu));
            checkOutput($sformatf("v%0d.rd_en_ex", i),     32'(rd_en_ex),     32'(vecs[i].e_rde));
            checkOutput($sformatf("v%0d.rd_addr_ex", i),   32'(rd_addr_ex),   32'(vecs[i].e_rda));
            checkOutput($sformatf("v%0d.load_flag_ex", i), 32'(load_flag_ex), 32'(vecs[i].e_lf));
        end

        // Single load-use stall cycle: counters cleared first, then one bubble.
        setData(32'h140, 1, 5'd3, 5'd0);
        setCtl(1, 0, 0, 1, 1);
        tick();
        setCtl(1, 1, 0, 1, 0);
        #1;
        checkOutput("stall.id_ready", 32'(id_ready), 32'h0);
        tick();
        checkBubble("stall");
        checkCounters("stall", 1, 0, 0);

        // Three-cycle hold of pc 0x200, then saturation and clear-wins-over-hold.
        setData(32'h200, 1, 5'd6, 5'd0);
        setCtl(1, 0, 0, 1, 1);
        tick();
        checkOutput("hold.capture_pc", pc_ex, 32'h200);
        setData(32'h204, 1, 5'd6, 5'd0);
        setCtl(1, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("hold%0d.pc_ex", c), pc_ex, 32'h200);
            checkOutput($sformatf("hold%0d.ex_valid", c), 32'(ex_valid), 32'h1);
        end
        checkCounters("hold", 0, 0, 3);
        checkOutput("hold.sat3", 32'(sat_hold_cnt), PERF ? 32'h3 : 32'h0);
        tick();
        checkOutput("hold.cnt4", hold_cnt, PERF ? 32'h4 : 32'h0);
        checkOutput("hold.sat_stays", 32'(sat_hold_cnt), PERF ? 32'h3 : 32'h0);
        setCtl(1, 0, 0, 0, 1);
        tick();
        checkOutput("clr_wins.hold_cnt", hold_cnt, 32'h0);
        checkOutput("clr_wins.sat", 32'(sat_hold_cnt), 32'h0);
        checkOutput("clr_wins.pc_ex", pc_ex, 32'h200);

        // Flush beats both hold and stall; bubble counter must not move.
        setCtl(1, 1, 0, 1, 0);
        tick();
        setData(32'h210, 1, 5'd2, 5'd1);
        setCtl(1, 0, 0, 1, 0);
        tick();
        checkOutput("flush.pre_pc", pc_ex, 32'h210);
        setCtl(1, 1, 1, 0, 0);
        tick();
        checkBubble("flush");
        checkCounters("flush", 1, 1, 0);

        // Asynchronous reset pulse between edges while holding.
        setData(32'h300, 1, 5'd4, 5'd2);
        setCtl(1, 0, 0, 1, 0);
        tick();
        checkOutput("arst.pre_pc", pc_ex, 32'h300);
        setCtl(1, 0, 0, 0, 0);
        tick();
        #3;
        rst = 1'b1;
        #1;
        checkBubble("arst");
        checkCounters("arst", 0, 0, 0);
        #1;
        rst = 1'b0;
        tick();
        checkBubble("arst.hold_empty");
        setData(32'h304, 1, 5'd4, 5'd0);
        setCtl(1, 0, 0, 1, 0);
        tick();
        checkOutput("arst.recap_valid", 32'(ex_valid), 32'h1);
        checkOutput("arst.recap_pc", pc_ex, 32'h304);
        checkOutput("arst.recap_rd_en", 32'(rd_en_ex), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 6, width of the ALU operation code.
REQ-002 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have id_valid  input  1  ID stage presents a valid instruction.
REQ-006 SHALL have rs1_data_id, rs2_data_id  input  `XLEN each  forwarded operands from the hazard/forwarding unit.
REQ-007 SHALL have imm_id, pc_id  input  `XLEN each  immediate and PC of the ID instruction.
REQ-008 SHALL have alu_op_id  input  ALU_OP_W; rd_en_id  input  1; rd_addr_id  input  `XREG_ADDRWIDTH; load_flag_id  input  5  (`NO_LOAD = not a load).
REQ-009 SHALL have load_hazerd_stall  input  1  load-use hazard from the hazard/forwarding unit.
REQ-010 SHALL have flush_ex  input  1  taken branch/jump resolved in EX; kill ID instruction.
REQ-011 SHALL have ex_ready  input  1  EX can accept a new instruction this cycle.
REQ-012 SHALL have perf_clr  input  1  synchronous clear of performance counters.
REQ-013 SHALL have id_ready  output  1  ID may advance; upstream IF/ID holds when low.
REQ-014 SHALL have ex_valid, rs1_ex, rs2_ex, imm_ex, pc_ex, alu_op_ex, rd_en_ex, rd_addr_ex, load_flag_ex  outputs, widths matching their _id counterparts, registered EX-stage copies.
REQ-015 SHALL have bubble_cnt, flush_cnt, hold_cnt  output  CNT_W each  performance counters.

Function
REQ-016 SHALL drive id_ready = ex_ready & ~load_hazerd_stall combinationally; no register in this path.
REQ-017 SHALL evaluate each clock with strict priority: flush_ex > hold (~ex_ready) > bubble (load_hazerd_stall) > capture (id_valid) > idle bubble.
REQ-018 SHALL on flush_ex load a bubble: ex_valid=0, rd_en_ex=`FALSE, load_flag_ex=`NO_LOAD, all data fields `ZERO_32BIT / 0; flush wins even when ex_ready=0.
REQ-019 SHALL on hold keep every output register unchanged, including ex_valid and a held bubble.
REQ-020 SHALL on load_hazerd_stall with ex_ready=1 load a bubble (as REQ-018), so the load advances and the dependent instruction re-presents next cycle.
REQ-021 SHALL on capture copy all _id fields into _ex registers with ex_valid=1; latency ID->EX exactly one cycle.
REQ-022 SHALL with id_valid=0 and no other event load a bubble.
REQ-023 SHALL never assert rd_en_ex or a load flag other than `NO_LOAD while ex_valid=0.
REQ-024 SHALL force rd_en_ex=`FALSE on capture when rd_addr_id=0 (x0 never written).
REQ-025 SHALL accept back-to-back captures every cycle with no inserted bubble when ex_ready=1 and no stall/flush.

Reset
REQ-026 SHALL on rst=1, asynchronously and regardless of clk, clear ex_valid, rd_en_ex, all data/address fields to 0, load_flag_ex to `NO_LOAD, and all counters to 0.
REQ-027 SHALL on rst mid-hold or mid-stall discard the held instruction; first cycle after release behaves per REQ-017 from empty.

Configuration
REQ-028 SHALL, when ID_EX_PERF_CNT_EN is defined, count per cycle: bubble_cnt on REQ-020 bubbles, flush_cnt on flush_ex, hold_cnt on hold; each saturates at all-ones; perf_clr zeroes all three and wins over increment.
REQ-029 SHALL, when ID_EX_PERF_CNT_EN is undefined, keep the counter ports and tie them to constant 0 with no counter flops; pipeline behaviour identical.

Verification
REQ-030 SHALL test: id_valid=1, pc_id=0x100, rd_addr_id=5, three cycles no events -> pc_ex=0x100,0x104,0x108 on consecutive cycles, ex_valid=1 throughout.
REQ-031 SHALL test: load_hazerd_stall=1 one cycle with ex_ready=1 -> id_ready=0 that cycle, next cycle ex_valid=0, rd_en_ex=0, load_flag_ex=`NO_LOAD, bubble_cnt=1.
REQ-032 SHALL test: ex_ready=0 for 3 cycles holding pc_ex=0x200 -> pc_ex stays 0x200, ex_valid=1, hold_cnt=3.
REQ-033 SHALL test: flush_ex=1 with ex_ready=0 and load_hazerd_stall=1 -> next cycle bubble, flush_cnt=1, bubble_cnt unchanged.
REQ-034 SHALL test: capture with rd_addr_id=0, rd_en_id=1 -> rd_en_ex=0, ex_valid=1.
REQ-035 SHALL test: rst pulse between clock edges during hold -> outputs zero immediately; with macro undefined all counters read 0.
